// File: rtl/config_loader.sv
// rtl/config_loader.sv - host-word to configuration-chain serializer with optional recirculating verify
//
// Purpose:
//   Accepts WORD_W-bit configuration words from a host over a valid/ready
//   handshake and shifts them MSB-first into the head of the logic-element
//   configuration chain. It issues exactly CHAIN_LEN shift strobes and then
//   reports done. Any bits left over in the final word are dropped.
//
// Optional feature (macro CONFIG_VERIFY_EN):
//   After the load, the chain is shifted CHAIN_LEN more times with its tail
//   fed back into its head. This leaves the chain contents unchanged.
//   A CRC-8 (poly 0x07, init 0x00) of the bits loaded is compared with a
//   CRC-8 of the bits returned from the chain tail. A difference sets error.
//   Without the macro there is no VERIFY state, error is tied low and
//   chain_return is ignored.
//
// Ports:
//   clk          - system/configuration clock
//   nrst         - asynchronous active-low reset
//   en           - global shift enable; the chain only advances while en=1
//   start        - one-cycle pulse that begins a load (only in IDLE or DONE)
//   wr_data      - host configuration word, bit WORD_W-1 is sent first
//   wr_valid     - wr_data valid
//   wr_ready     - loader accepts a word this cycle (FETCH only)
//   cfg_data_out - serial bit to the chain head config_data_in
//   cfg_en       - shift strobe to every chain element
//   chain_return - config_data_out of the last chain element
//   busy         - load or verify in progress
//   done         - load (and verify) complete; held until the next start
//   error        - verify mismatch; held until the next start
module config_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              cfg_data_out,
    output logic              cfg_en,
    input  logic              chain_return,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
`ifdef CONFIG_VERIFY_EN
        S_VERIFY,
`endif
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  bit_idx;

    logic start_run;
    logic load_word;
    logic shift_step;
    logic last_bit;

    // The shift that brings the counter to CHAIN_LEN is the final one.
    assign last_bit = (bit_cnt == LAST_CNT);

`ifdef CONFIG_VERIFY_EN
    logic       verify_step;
    logic [7:0] crc_a;
    logic [7:0] crc_b;
    logic [7:0] crc_b_nxt;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign crc_b_nxt = crc8_step(crc_b, chain_return);
`else
    logic unused_chain_return;
    assign unused_chain_return = chain_return;
    assign error = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        wr_ready     = 1'b0;
        cfg_en       = 1'b0;
        cfg_data_out = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        start_run    = 1'b0;
        load_word    = 1'b0;
        shift_step   = 1'b0;
`ifdef CONFIG_VERIFY_EN
        verify_step  = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    start_run = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                wr_ready = 1'b1;
                if (wr_valid) begin
                    load_word = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy         = 1'b1;
                cfg_en       = en;
                cfg_data_out = en & shreg[WORD_W-1];
                if (en) begin
                    shift_step = 1'b1;
                    if (last_bit) begin
`ifdef CONFIG_VERIFY_EN
                        state_nxt = S_VERIFY;
`else
                        state_nxt = S_DONE;
`endif
                    end else if (bit_idx == '0) begin
                        state_nxt = S_FETCH;
                    end
                end
            end
`ifdef CONFIG_VERIFY_EN
            S_VERIFY: begin
                // Tail is fed back into the head so the chain ends as loaded.
                busy         = 1'b1;
                cfg_en       = en;
                cfg_data_out = en & chain_return;
                if (en) begin
                    verify_step = 1'b1;
                    if (last_bit) begin
                        state_nxt = S_DONE;
                    end
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                bit_cnt <= '0;
            end
            if (load_word) begin
                shreg   <= wr_data;
                bit_idx <= TOP_IDX;
            end
            if (shift_step) begin
                shreg   <= shreg << 1;
                bit_idx <= bit_idx - 1'b1;
`ifdef CONFIG_VERIFY_EN
                // The counter restarts so that it also counts the verify pass.
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
`else
                bit_cnt <= bit_cnt + 1'b1;
`endif
            end
`ifdef CONFIG_VERIFY_EN
            if (verify_step) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
`endif
        end
    end

`ifdef CONFIG_VERIFY_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc_a <= 8'h00;
            crc_b <= 8'h00;
            error <= 1'b0;
        end else begin
            if (start_run) begin
                crc_a <= 8'h00;
                crc_b <= 8'h00;
                error <= 1'b0;
            end
            if (shift_step) begin
                crc_a <= crc8_step(crc_a, shreg[WORD_W-1]);
            end
            if (verify_step) begin
                crc_b <= crc_b_nxt;
                // Compare using the CRC that includes the final returned bit.
                if (last_bit && (crc_b_nxt != crc_a)) begin
                    error <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - self-checking bench for config_loader with a behavioural chain model
module tb_config_loader;

    localparam int CL     = 20;
    localparam int WW     = 8;
    localparam int NWORDS = (CL + WW - 1) / WW;
`ifdef CONFIG_VERIFY_EN
    localparam int EXP_PULSES = 2 * CL;
`else
    localparam int EXP_PULSES = CL;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          start;
    logic [WW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          cfg_data_out;
    logic          cfg_en;
    logic          chain_return;
    logic          busy;
    logic          done;
    logic          error;

    int tests = 0;
    int fails = 0;

    config_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .start        (start),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .cfg_data_out (cfg_data_out),
        .cfg_en       (cfg_en),
        .chain_return (chain_return),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Behavioural chain: CL-bit shift register, head at index 0, tail at CL-1.
    logic [CL-1:0] chain;
    logic          s_en;
    logic          s_d;
    bit            stuck_en = 1'b0;
    int            stuck_pos = 0;

    always @(negedge clk) begin
        s_en <= cfg_en;
        s_d  <= cfg_data_out;
    end

    always @(posedge clk) begin
        logic [CL-1:0] nx;
        nx = chain;
        if (s_en) nx = {chain[CL-2:0], s_d};
        if (stuck_en) nx[stuck_pos] = 1'b0;
        chain <= nx;
    end

    assign chain_return = chain[CL-1];

    logic [WW-1:0] words[$];
    bit            cap[$];
    int            pulses;
    int            first_pulse_cyc;
    int            last_pulse_cyc;
    int            done_cyc;
    int            consumed;
    bit            bad_idle_out;
    bit            bad_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Runs one load from IDLE/DONE. Called at posedge+1; returns at posedge+1
    // unless aborted, in which case it returns at the negedge after abort_at pulses.
    task automatic run_load(input bit stall5, input int gap, input int abort_at,
                            input bit poke_start, input bit rand_en);
        int  widx;
        int  gap_cnt;
        int  stall_left;
        bit  stalled_once;
        cap.delete();
        pulses = 0; first_pulse_cyc = -1; last_pulse_cyc = -1; done_cyc = -1;
        bad_idle_out = 0; bad_stall = 0;
        widx = 0; gap_cnt = gap; stall_left = 0; stalled_once = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            en = 1'b1;
            if (rand_en) en = ($urandom_range(0, 3) != 0);
            if (stall5 && !stalled_once && pulses == 3) begin
                stall_left = 5;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                en = 1'b0;
                stall_left--;
            end
            start    = poke_start && (pulses == 5);
            wr_valid = (gap_cnt == 0);
            wr_data  = (widx < words.size()) ? words[widx] : 8'hEE;
            @(negedge clk);
            if (cyc == 0) begin
                chk("start_clears", {busy, done, error}, 3'b100);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (!cfg_en && cfg_data_out) bad_idle_out = 1;
            if (!en && cfg_en) bad_stall = 1;
            if (cfg_en) begin
                if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
                last_pulse_cyc = cyc;
                cap.push_back(cfg_data_out);
                pulses++;
            end
            if (wr_ready) begin
                if (wr_valid) begin
                    widx++;
                    gap_cnt = gap;
                end else if (gap_cnt > 0) begin
                    gap_cnt--;
                end
            end
            if (abort_at > 0 && pulses == abort_at) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        consumed = widx;
        if (abort_at == 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_load(input string tag);
        logic [CL-1:0] expv;
        logic [CL-1:0] got;
        logic [CL-1:0] got_v;
        for (int i = 0; i < CL; i++) begin
            expv[CL-1-i] = words[i / WW][WW - 1 - (i % WW)];
            got[CL-1-i]  = (i < cap.size()) ? cap[i] : 1'b0;
            got_v[CL-1-i] = (CL + i < cap.size()) ? cap[CL + i] : 1'b0;
        end
        chk({tag, "_pulses"}, pulses, EXP_PULSES);
        chk({tag, "_bits"}, got, expv);
        chk({tag, "_done_lat"}, done_cyc, last_pulse_cyc + 1);
        chk({tag, "_words"}, consumed, NWORDS);
        chk({tag, "_idle_out"}, bad_idle_out, 0);
        chk({tag, "_stall"}, bad_stall, 0);
        chk({tag, "_chain"}, chain, expv);
        chk({tag, "_err"}, error, 0);
`ifdef CONFIG_VERIFY_EN
        chk({tag, "_vbits"}, got_v, expv);
`endif
    endtask

    initial begin
        bit bad;
        nrst = 1'b0; en = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {wr_ready, cfg_en, cfg_data_out, busy, done, error}, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // Directed back-to-back load.
        words = '{8'hA5, 8'h3C, 8'hF0};
        run_load(0, 0, 0, 0, 0);
        check_load("t1");
        chk("t1_first_pulse", first_pulse_cyc, 1);
        chk("t1_latency", done_cyc, NWORDS + EXP_PULSES);
        bad = 0;
        wr_valid = 1'b1; wr_data = 8'h77;
        repeat (4) begin
            @(negedge clk);
            if (wr_ready || !done || busy) bad = 1;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        chk("t1_ready_after", bad, 0);

        // en stall mid-word and 3-cycle valid gaps.
        run_load(1, 3, 0, 0, 0);
        check_load("t2");

        // Asynchronous reset after 9 bits, then a full reload.
        run_load(0, 0, 9, 0, 0);
        chk("t3_reached", {pulses[15:0], busy}, {16'd9, 1'b1});
        nrst = 1'b0;
        #1;
        chk("t3_async_rst", {wr_ready, cfg_en, cfg_data_out, busy, done, error}, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        run_load(0, 0, 0, 0, 0);
        check_load("t3_reload");

        // start pulsed during SHIFT is ignored.
        run_load(0, 0, 0, 1, 0);
        check_load("t4");

        // Randomized words, enable pattern and host gaps.
        for (int k = 0; k < 4; k++) begin
            words = '{WW'($urandom), WW'($urandom), WW'($urandom)};
            run_load(0, $urandom_range(0, 3), 0, 0, 1);
            check_load($sformatf("rnd%0d", k));
        end

`ifdef CONFIG_VERIFY_EN
        // Chain with a cell stuck at 0 must be reported.
        words = '{8'hA5, 8'h3C, 8'hF0};
        stuck_en = 1'b1;
        stuck_pos = 10;
        run_load(0, 0, 0, 0, 0);
        chk("stuck_pulses", pulses, 2 * CL);
        chk("stuck_done_err", {done, error}, 2'b11);
        stuck_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
